// File: rtl/bp_pkg.sv
// Shared gshare predictor definitions: widths, counter encodings, index/tag
// extraction and the AGEX -> FE update bundle.
package bp_pkg;

  localparam int DBITS          = 32;
  localparam int PT_INDEX_BITS  = 8;
  localparam int BTB_INDEX_BITS = 4;
  localparam int BHR_BITS       = 8;
  localparam int TAG_BITS       = DBITS - BTB_INDEX_BITS - 2;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef struct packed {
    logic                      valid;
    logic [DBITS-1:0]          pc;
    logic [DBITS-1:0]          target;
    logic                      taken;
    logic                      mispredict;
    logic [PT_INDEX_BITS-1:0]  pt_index;
    logic [BTB_INDEX_BITS-1:0] btb_index;
    logic [BHR_BITS-1:0]       bhr;
  } bp_update_t;

  // Word-aligned PCs: the two low bits never take part in indexing.
  function automatic logic [PT_INDEX_BITS-1:0] pt_index_of(input logic [DBITS-1:0] pc,
                                                           input logic [BHR_BITS-1:0] hist);
    return PT_INDEX_BITS'(pc >> 2) ^ hist;
  endfunction

  function automatic logic [BTB_INDEX_BITS-1:0] btb_index_of(input logic [DBITS-1:0] pc);
    return BTB_INDEX_BITS'(pc >> 2);
  endfunction

  function automatic logic [TAG_BITS-1:0] btb_tag_of(input logic [DBITS-1:0] pc);
    return TAG_BITS'(pc >> (BTB_INDEX_BITS + 2));
  endfunction

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Branch target buffer: combinational read of the pre-edge contents, one
// registered write port, so a same-cycle write is seen only by later reads.
module bp_btb #(
  parameter int INDEX_BITS = bp_pkg::BTB_INDEX_BITS,
  parameter int TAG_W      = bp_pkg::TAG_BITS,
  parameter int DW         = bp_pkg::DBITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_index,
  input  logic [TAG_W-1:0]      rd_tag,
  output logic                  rd_hit,
  output logic [DW-1:0]         rd_target,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DW-1:0]         wr_target
);
  import bp_pkg::*;

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [DW-1:0]      target [ENTRIES];

  assign rd_hit    = valid[rd_index] && (tag[rd_index] == rd_tag);
  assign rd_target = target[rd_index];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
      end
    end else if (wr_en) begin
      valid[wr_index]  <= 1'b1;
      tag[wr_index]    <= wr_tag;
      target[wr_index] <= wr_target;
    end
  end

endmodule

// File: rtl/fe_branch_predictor.sv
// Fetch-side gshare predictor: PT, speculative BHR and BTB lookup with a
// registered prediction, trained and recovered by resolved branches from AGEX.
module fe_branch_predictor #(
  parameter int DBITS          = bp_pkg::DBITS,
  parameter int PT_INDEX_BITS  = bp_pkg::PT_INDEX_BITS,
  parameter int BTB_INDEX_BITS = bp_pkg::BTB_INDEX_BITS,
  parameter int BHR_BITS       = bp_pkg::BHR_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_valid,
  input  logic                      fetch_stall,
  input  logic [DBITS-1:0]          fetch_pc,
  output logic                      pred_valid,
  output logic                      pred_taken,
  output logic                      pred_btb_hit,
  output logic [DBITS-1:0]          pred_next_pc,
  output logic [PT_INDEX_BITS-1:0]  pred_pt_index,
  output logic [BTB_INDEX_BITS-1:0] pred_btb_index,
  output logic [BHR_BITS-1:0]       pred_bhr,
  input  logic                      upd_valid,
  input  logic [DBITS-1:0]          upd_pc,
  input  logic [DBITS-1:0]          upd_target,
  input  logic                      upd_taken,
  input  logic                      upd_mispredict,
  input  logic [PT_INDEX_BITS-1:0]  upd_pt_index,
  input  logic [BTB_INDEX_BITS-1:0] upd_btb_index,
  input  logic [BHR_BITS-1:0]       upd_bhr
);
  import bp_pkg::*;

  localparam int PT_ENTRIES = 1 << PT_INDEX_BITS;

  bp_update_t upd;
  always_comb begin
    upd            = '0;
    upd.valid      = upd_valid;
    upd.pc         = upd_pc;
    upd.target     = upd_target;
    upd.taken      = upd_taken;
    upd.mispredict = upd_mispredict;
    upd.pt_index   = upd_pt_index;
    upd.btb_index  = upd_btb_index;
    upd.bhr        = upd_bhr;
  end

  logic [1:0]                pt [PT_ENTRIES];
  logic [BHR_BITS-1:0]       bhr;
  logic [PT_INDEX_BITS-1:0]  lk_pt_index;
  logic [BTB_INDEX_BITS-1:0] lk_btb_index;
  logic [TAG_BITS-1:0]       lk_tag;
  logic [TAG_BITS-1:0]       wr_tag;
  logic                      lk_hit;
  logic                      lk_taken;
  logic [DBITS-1:0]          lk_target;
  logic [DBITS-1:0]          lk_next_pc;
  logic                      recover;
  logic                      accept;

  assign lk_pt_index  = pt_index_of(fetch_pc, bhr);
  assign lk_btb_index = btb_index_of(fetch_pc);
  assign lk_tag       = btb_tag_of(fetch_pc);
  assign wr_tag       = btb_tag_of(upd.pc);

  bp_btb u_btb (
    .clk       (clk),
    .reset     (reset),
    .rd_index  (lk_btb_index),
    .rd_tag    (lk_tag),
    .rd_hit    (lk_hit),
    .rd_target (lk_target),
    .wr_en     (upd.valid && upd.taken),
    .wr_index  (upd.btb_index),
    .wr_tag    (wr_tag),
    .wr_target (upd.target)
  );

  assign lk_taken   = lk_hit && pt[lk_pt_index][1];
  assign lk_next_pc = lk_taken ? lk_target : fetch_pc + DBITS'(4);

  // A mispredict squashes the same-cycle lookup: its history is already wrong.
  assign recover = upd.valid && upd.mispredict;
  assign accept  = fetch_valid && !fetch_stall && !recover;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PT_ENTRIES; i++) pt[i] <= WNT;
    end else if (upd.valid) begin
      pt[upd.pt_index] <= ctr_next(pt[upd.pt_index], upd.taken);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bhr <= '0;
    end else if (recover) begin
      bhr <= {upd.bhr[BHR_BITS-2:0], upd.taken};
    end else if (accept && lk_hit) begin
      bhr <= {bhr[BHR_BITS-2:0], lk_taken};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_valid     <= 1'b0;
      pred_taken     <= 1'b0;
      pred_btb_hit   <= 1'b0;
      pred_next_pc   <= '0;
      pred_pt_index  <= '0;
      pred_btb_index <= '0;
      pred_bhr       <= '0;
    end else if (!fetch_stall) begin
      pred_valid <= accept;
      if (accept) begin
        pred_taken     <= lk_taken;
        pred_btb_hit   <= lk_hit;
        pred_next_pc   <= lk_next_pc;
        pred_pt_index  <= lk_pt_index;
        pred_btb_index <= lk_btb_index;
        pred_bhr       <= bhr;
      end
    end
  end

endmodule

// File: tb/tb_fe_branch_predictor.sv
// Bench for fe_branch_predictor: hand-derived vector table, a mid-stream reset
// sequence, then random traffic against an array-based gshare model.
module tb_fe_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid, fetch_stall;
  logic [31:0] fetch_pc;
  logic        pred_valid, pred_taken, pred_btb_hit;
  logic [31:0] pred_next_pc;
  logic [7:0]  pred_pt_index;
  logic [3:0]  pred_btb_index;
  logic [7:0]  pred_bhr;
  logic        upd_valid, upd_taken, upd_mispredict;
  logic [31:0] upd_pc, upd_target;
  logic [7:0]  upd_pt_index, upd_bhr;
  logic [3:0]  upd_btb_index;

  always #5 clk = ~clk;

  fe_branch_predictor dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_stall(fetch_stall), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_btb_hit(pred_btb_hit),
    .pred_next_pc(pred_next_pc), .pred_pt_index(pred_pt_index),
    .pred_btb_index(pred_btb_index), .pred_bhr(pred_bhr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .upd_pt_index(upd_pt_index), .upd_btb_index(upd_btb_index), .upd_bhr(upd_bhr)
  );

  typedef struct {
    bit fv; bit st; logic [31:0] pc;
    bit uv; logic [31:0] upc; logic [31:0] utgt; bit ut; bit um;
    logic [7:0] upti; logic [3:0] ubti; logic [7:0] ubhr;
    bit ev; bit eh; bit et; logic [31:0] enx; logic [7:0] ebhr;
  } vec_t;

  vec_t vecs[24];
  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  int          m_pt[256];
  bit          m_v[16];
  logic [31:0] m_tag[16];
  logic [31:0] m_tgt[16];
  int          m_bhr;
  bit          e_valid, e_hit, e_taken;
  logic [31:0] e_next;
  int          e_pti, e_bti, e_bhr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_valid = 0; fetch_stall = 0; fetch_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0; upd_mispredict = 0;
    upd_pt_index = 0; upd_btb_index = 0; upd_bhr = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_pt[i] = 1;
    for (int i = 0; i < 16; i++) begin m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; end
    m_bhr = 0;
    e_valid = 0; e_hit = 0; e_taken = 0; e_next = 0; e_pti = 0; e_bti = 0; e_bhr = 0;
  endtask

  // One clock of the predictor, from the current inputs, in plain arithmetic.
  task automatic model_cycle();
    int pti, bti, ctr;
    bit hit, tk, rec, acc;
    pti = ((fetch_pc >> 2) % 256) ^ m_bhr;
    bti = (fetch_pc >> 2) % 16;
    hit = m_v[bti] && (m_tag[bti] == (fetch_pc >> 6));
    tk  = hit && (m_pt[pti] >= 2);
    rec = upd_valid && upd_mispredict;
    acc = fetch_valid && !fetch_stall && !rec;
    if (!fetch_stall) begin
      e_valid = acc;
      if (acc) begin
        e_hit = hit; e_taken = tk; e_pti = pti; e_bti = bti; e_bhr = m_bhr;
        e_next = tk ? m_tgt[bti] : fetch_pc + 32'd4;
      end
    end
    if (rec) m_bhr = (upd_bhr * 2 + upd_taken) % 256;
    else if (acc && hit) m_bhr = (m_bhr * 2 + tk) % 256;
    if (upd_valid) begin
      ctr = m_pt[upd_pt_index] + (upd_taken ? 1 : -1);
      m_pt[upd_pt_index] = (ctr > 3) ? 3 : (ctr < 0) ? 0 : ctr;
      if (upd_taken) begin
        m_v[upd_btb_index] = 1;
        m_tag[upd_btb_index] = upd_pc >> 6;
        m_tgt[upd_btb_index] = upd_target;
      end
    end
  endtask

  initial begin
    // fields: fv st pc | uv upc utgt ut um upti ubti ubhr | ev eh et enx ebhr
    vecs = '{
      '{1'b1,1'b0,32'h100,       1'b0,32'h0,  32'h0,  1'b0,1'b0,8'h00,4'h0,8'h00, 1'b1,1'b0,1'b0,32'h104,8'h00},
      '{1'b0,1'b0,32'h0,         1'b1,32'h100,32'h200,1'b1,1'b0,8'h40,4'h0,8'h00, 1'b0,1'b0,1'b0,32'h104,8'h00},
      '{1'b0,1'b0,32'h0,         1'b1,32'h100,32'h200,1'b1,1'b0,8'h40,4'h0,8'h00, 1'b0,1'b0,1'b0,32'h104,8'h00},
      '{1'b1,1'b0,32'h100,       1'b0,32'h0,  32'h0,  1'b0,1'b0,8'h00,4'h0,8'h00, 1'b1,1'b1,1'b1,32'h200,8'h00},
      '{1'b1,1'b0,32'h100,       1'b0,32'h0,  32'h0,  1'b0,1'b0,8'h00,4'h0,8'h00, 1'b1,1'b1,1'b0,32'h104,8'h01},
      '{1'b0,1'b0,32'h0,         1'b1,32'h100,32'h200,1'b0,1'b0,8'h40,4'h0,8'h00, 1'b0,1'b1,1'b0,32'h104,8'h01},
      '{1'b0,1'b0,32'h0,         1'b1,32'h100,32'h200,1'b0,1'b0,8'h40,4'h0,8'h00, 1'b0,1'b1,1'b0,32'h104,8'h01},
      '{1'b0,1'b0,32'h0,         1'b1,32'h100,32'h200,1'b0,1'b0,8'h40,4'h0,8'h00, 1'b0,1'b1,1'b0,32'h104,8'h01},
      '{1'b0,1'b0,32'h0,         1'b1,32'h100,32'h200,1'b0,1'b0,8'h40,4'h0,8'h00, 1'b0,1'b1,1'b0,32'h104,8'h01},
      '{1'b0,1'b0,32'h0,         1'b1,32'h200,32'h0,  1'b0,1'b1,8'h80,4'h0,8'h00, 1'b0,1'b1,1'b0,32'h104,8'h01},
      '{1'b1,1'b0,32'h100,       1'b0,32'h0,  32'h0,  1'b0,1'b0,8'h00,4'h0,8'h00, 1'b1,1'b1,1'b0,32'h104,8'h00},
      '{1'b0,1'b0,32'h0,         1'b1,32'h104,32'h300,1'b1,1'b0,8'h41,4'h1,8'h00, 1'b0,1'b1,1'b0,32'h104,8'h00},
      '{1'b0,1'b0,32'h0,         1'b1,32'h104,32'h300,1'b1,1'b0,8'h40,4'h1,8'h00, 1'b0,1'b1,1'b0,32'h104,8'h00},
      '{1'b0,1'b0,32'h0,         1'b1,32'h104,32'h300,1'b1,1'b0,8'h40,4'h1,8'h00, 1'b0,1'b1,1'b0,32'h104,8'h00},
      '{1'b1,1'b0,32'h104,       1'b0,32'h0,  32'h0,  1'b0,1'b0,8'h00,4'h0,8'h00, 1'b1,1'b1,1'b1,32'h300,8'h00},
      '{1'b1,1'b0,32'h104,       1'b0,32'h0,  32'h0,  1'b0,1'b0,8'h00,4'h0,8'h00, 1'b1,1'b1,1'b1,32'h300,8'h01},
      '{1'b1,1'b0,32'h104,       1'b1,32'h114,32'h0,  1'b0,1'b1,8'h90,4'h5,8'h01, 1'b0,1'b1,1'b1,32'h300,8'h01},
      '{1'b1,1'b0,32'h100,       1'b0,32'h0,  32'h0,  1'b0,1'b0,8'h00,4'h0,8'h00, 1'b1,1'b1,1'b0,32'h104,8'h02},
      '{1'b1,1'b0,32'h108,       1'b1,32'h108,32'h400,1'b1,1'b0,8'h46,4'h2,8'h00, 1'b1,1'b0,1'b0,32'h10C,8'h04},
      '{1'b1,1'b0,32'h108,       1'b0,32'h0,  32'h0,  1'b0,1'b0,8'h00,4'h0,8'h00, 1'b1,1'b1,1'b1,32'h400,8'h04},
      '{1'b1,1'b1,32'h100,       1'b0,32'h0,  32'h0,  1'b0,1'b0,8'h00,4'h0,8'h00, 1'b1,1'b1,1'b1,32'h400,8'h04},
      '{1'b1,1'b0,32'h100,       1'b0,32'h0,  32'h0,  1'b0,1'b0,8'h00,4'h0,8'h00, 1'b1,1'b1,1'b0,32'h104,8'h09},
      '{1'b1,1'b0,32'hFFFFFFFC,  1'b0,32'h0,  32'h0,  1'b0,1'b0,8'h00,4'h0,8'h00, 1'b1,1'b0,1'b0,32'h0,  8'h12},
      '{1'b0,1'b0,32'h100,       1'b0,32'h0,  32'h0,  1'b0,1'b0,8'h00,4'h0,8'h00, 1'b0,1'b0,1'b0,32'h0,  8'h12}
    };

    idle_inputs();
    reset = 1'b0;
    tick();
    check("reset valid", pred_valid, 0);
    check("reset next_pc", pred_next_pc, 0);
    tick();
    reset = 1'b1;

    for (int i = 0; i < 24; i++) begin
      fetch_valid = vecs[i].fv; fetch_stall = vecs[i].st; fetch_pc = vecs[i].pc;
      upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_target = vecs[i].utgt;
      upd_taken = vecs[i].ut; upd_mispredict = vecs[i].um; upd_pt_index = vecs[i].upti;
      upd_btb_index = vecs[i].ubti; upd_bhr = vecs[i].ubhr;
      tick();
      check($sformatf("v%0d valid", i), pred_valid, vecs[i].ev);
      check($sformatf("v%0d hit", i), pred_btb_hit, vecs[i].eh);
      check($sformatf("v%0d taken", i), pred_taken, vecs[i].et);
      check($sformatf("v%0d next_pc", i), pred_next_pc, vecs[i].enx);
      check($sformatf("v%0d bhr", i), pred_bhr, vecs[i].ebhr);
    end

    // Asynchronous reset between edges while the BTB holds trained entries.
    idle_inputs();
    #3 reset = 1'b0;
    #1;
    check("async reset valid", pred_valid, 0);
    check("async reset hit", pred_btb_hit, 0);
    check("async reset next_pc", pred_next_pc, 0);
    model_reset();
    tick();
    reset = 1'b1;
    fetch_valid = 1; fetch_pc = 32'h100;
    model_cycle();
    tick();
    check("post-reset valid", pred_valid, 1);
    check("post-reset hit", pred_btb_hit, 0);
    check("post-reset next_pc", pred_next_pc, 32'h104);
    check("post-reset pt_index", pred_pt_index, 32'h40);
    check("post-reset bhr", pred_bhr, 0);

    for (int c = 0; c < 600; c++) begin
      fetch_valid = ($urandom_range(0, 3) != 0);
      fetch_stall = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) fetch_pc = $urandom() & 32'hFFFF_FFFC;
      else fetch_pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      upd_valid = $urandom_range(0, 1);
      upd_pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      upd_target = $urandom() & 32'hFFFF_FFFC;
      upd_taken = $urandom_range(0, 1);
      upd_mispredict = ($urandom_range(0, 7) == 0);
      upd_pt_index = 8'($urandom_range(0, 255));
      upd_btb_index = 4'(upd_pc >> 2);
      upd_bhr = 8'($urandom_range(0, 255));
      model_cycle();
      tick();
      check("rnd valid", pred_valid, e_valid);
      check("rnd hit", pred_btb_hit, e_hit);
      check("rnd taken", pred_taken, e_taken);
      check("rnd next_pc", pred_next_pc, e_next);
      check("rnd pt_index", pred_pt_index, e_pti);
      check("rnd btb_index", pred_btb_index, e_bti);
      check("rnd bhr", pred_bhr, e_bhr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fe_branch_predictor.md
# fe_branch_predictor

Fetch-side gshare branch predictor: the read/lookup end of the predictor state that the execute stage (AGEX) trains. Each fetched PC gets a registered prediction one cycle later: taken/not-taken, next PC, plus the indices and BHR checkpoint that travel down FE→DE→AGEX. The block owns the PT, BTB and speculative BHR and accepts one resolved-branch update per cycle from AGEX, including misprediction history recovery.

## Interface
- `DBITS`, 32, PC/target width
- `PT_INDEX_BITS`, 8, pattern table has 2^8 2-bit counters
- `BTB_INDEX_BITS`, 4, BTB has 16 entries
- `BHR_BITS`, 8, global history width (== `PT_INDEX_BITS`)
- `clk` in 1, single clock
- `reset` in 1, asynchronous, active-low
- `fetch_valid` in 1, lookup request for `fetch_pc`
- `fetch_stall` in 1, hold all prediction outputs and BHR
- `fetch_pc` in DBITS, PC being fetched (word aligned)
- `pred_valid` out 1, prediction outputs valid
- `pred_taken` out 1, BTB hit and counter MSB set
- `pred_btb_hit` out 1, valid entry with matching tag
- `pred_next_pc` out DBITS, BTB target if `pred_taken`, else PC+4
- `pred_pt_index` out PT_INDEX_BITS, index used
- `pred_btb_index` out BTB_INDEX_BITS, index used
- `pred_bhr` out BHR_BITS, BHR value before this prediction's shift
- `upd_valid` in 1, resolved branch/jump from AGEX
- `upd_pc`, `upd_target` in DBITS each, branch PC and actual target
- `upd_taken` in 1, actual direction
- `upd_mispredict` in 1, direction or target mispredicted
- `upd_pt_index`, `upd_btb_index`, `upd_bhr` in matching widths, values carried from prediction

## Operation
- PT index = `fetch_pc[PT_INDEX_BITS+1:2] ^ bhr`; BTB index = `fetch_pc[BTB_INDEX_BITS+1:2]`; tag = `fetch_pc[DBITS-1:BTB_INDEX_BITS+2]`.
- Counters: 2-bit saturating; predict taken iff counter ≥ 2. Update: taken → +1 saturate at 3; not taken → −1 saturate at 0.
- BTB entry: valid, tag, target. On `upd_valid && upd_taken`: write valid=1, tag of `upd_pc`, `upd_target` at `upd_btb_index`. Not-taken updates leave BTB unchanged.
- PT written at `upd_pt_index` on every `upd_valid`.
- Speculative BHR: on accepted lookup with BTB hit, `bhr <= {bhr[BHR_BITS-2:0], pred_taken}`. BTB miss: BHR unchanged.
- Recovery: `upd_valid && upd_mispredict` → `bhr <= {upd_bhr[BHR_BITS-2:0], upd_taken}`.
- Non-mispredict updates never touch BHR.

## Timing
- Reset (asserted low, async): BHR=0, all PT counters=1 (weakly not-taken), all BTB valid=0, `pred_valid`=0, all other outputs 0.
- Lookup latency 1: `fetch_valid` at cycle N → outputs registered at N+1.
- `fetch_stall`=1: outputs, BHR hold; lookup ignored; table updates still performed.
- Table reads are read-before-write: same-cycle update to the same PT/BTB entry is not visible to that lookup; visible the next cycle.
- Mispredict and lookup same cycle: recovery wins; lookup dropped, `pred_valid`=0 next cycle; BHR takes recovery value only.
- `fetch_valid`=0 (not stalled): `pred_valid`=0 next cycle, other outputs hold.
- PC+4 wraps modulo 2^DBITS.

## Structure
- Shared package `bp_pkg`: width parameters, counter constants (SNT=0, WNT=1, WT=2, ST=3), index/tag extraction functions, update-bundle struct reused by AGEX.
- One sub-module `bp_btb`: valid/tag/target array with read-before-write lookup and single write port.
- PT and BHR live in the top module.

## Test plan
- Reset, lookup PC 0x100 → `pred_valid`=1, `pred_btb_hit`=0, `pred_taken`=0, `pred_next_pc`=0x104, `pred_bhr`=0.
- Update PC 0x100 taken target 0x200 (pt index 0x40) twice; lookup 0x100 with BHR=0 → hit, counter 3, `pred_next_pc`=0x200, next BHR=0x01.
- Three not-taken updates on a counter at 3 then one more → counter 0, stays 0 (saturation); lookup predicts not-taken.
- Speculate BHR to 0x03, then mispredict with `upd_bhr`=0x01, `upd_taken`=0 plus simultaneous lookup → BHR=0x02, `pred_valid`=0 next cycle.
- Update and lookup same BTB entry same cycle → lookup reports old (miss); repeat next cycle → hit.
- Assert `reset` low mid-stream with valid BTB entries → immediately `pred_valid`=0; after release, lookup of previously trained PC misses.
